// File: rtl/crc32_parallel.sv
// Ethernet CRC-32 generator/checker. It consumes P_DW/8 bytes per cycle with byte enables on
// the last beat. Defining CRC32_PARALLEL_CHECK_EN adds the FCS residue check on o_crc_ok.
module crc32_parallel #(
  parameter int unsigned P_DW   = 8,
  parameter logic [31:0] P_INIT = 32'hFFFFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_sof,
  input  logic              i_eof,
  input  logic [P_DW-1:0]   i_data,
  input  logic [P_DW/8-1:0] i_keep,
  output logic [31:0]       o_crc,
  output logic              o_crc_valid,
  output logic              o_abort,
  output logic              o_crc_ok
);

  localparam int unsigned NB      = P_DW / 8;
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic {StIdle, StActive} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_crc;
  logic [31:0]     r_crc_out;
  logic            r_crc_valid;
  logic            r_abort;
  logic            w_consume;
  logic            w_abort;
  logic            w_done;
  logic [NB-1:0]   w_keep;
  logic [31:0]     w_seed;
  logic [31:0]     w_crc_next;

  // Byte-serial reflected CRC, fully unrolled so a whole beat settles in one cycle.
  function automatic logic [31:0] crc_bytes(input logic [31:0]   crc,
                                            input logic [P_DW-1:0] data,
                                            input logic [NB-1:0]   keep);
    logic [31:0] c;
    c = crc;
    for (int b = 0; b < NB; b++) begin
      if (keep[b]) begin
        c = c ^ {24'h000000, data[8*b +: 8]};
        for (int k = 0; k < 8; k++) begin
          c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_consume    = 1'b0;
    w_abort      = 1'b0;
    if (i_en) begin
      if (i_sof) begin
        w_consume    = 1'b1;
        w_abort      = (r_state == StActive);
        w_state_next = i_eof ? StIdle : StActive;
      end else if (r_state == StActive) begin
        w_consume = 1'b1;
        if (i_eof) begin
          w_state_next = StIdle;
        end
      end
    end
    w_done     = w_consume & i_eof;
    w_keep     = i_eof ? i_keep : {NB{1'b1}};
    w_seed     = i_sof ? P_INIT : r_crc;
    w_crc_next = crc_bytes(w_seed, i_data, w_keep);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_crc       <= P_INIT;
      r_crc_out   <= 32'h00000000;
      r_crc_valid <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_crc_valid <= w_done;
      r_abort     <= w_abort;
      if (w_consume) begin
        r_crc     <= w_crc_next;
        r_crc_out <= ~w_crc_next;
      end
    end
  end

`ifdef CRC32_PARALLEL_CHECK_EN
  logic r_crc_ok;

  // A frame that carries its own FCS leaves the fixed residue in the raw register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_crc_ok <= 1'b0;
    end else begin
      r_crc_ok <= w_done & (w_crc_next == RESIDUE);
    end
  end

  assign o_crc_ok = r_crc_ok;
`else
  assign o_crc_ok = 1'b0;
`endif

  assign o_crc       = r_crc_out;
  assign o_crc_valid = r_crc_valid;
  assign o_abort     = r_abort;

endmodule

// File: tb/tb_crc32_parallel.sv
// Directed bench for crc32_parallel at 8-, 32- and 64-bit data widths, one instance each.
module tb_crc32_parallel;

`ifdef CRC32_PARALLEL_CHECK_EN
  localparam logic ExpOk = 1'b1;
`else
  localparam logic ExpOk = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic        en8, sof8, eof8, k8;
  logic [7:0]  d8;
  logic [31:0] crc8;
  logic        val8, abt8, ok8;

  logic        en32, sof32, eof32;
  logic [31:0] d32;
  logic [3:0]  k32;
  logic [31:0] crc32;
  logic        val32, abt32, ok32;

  logic        en64, sof64, eof64;
  logic [63:0] d64;
  logic [7:0]  k64;
  logic [31:0] crc64;
  logic        val64, abt64, ok64;

  logic [7:0] s9  [9];
  logic [7:0] fcs [4];

  crc32_parallel #(.P_DW(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_en(en8), .i_sof(sof8), .i_eof(eof8), .i_data(d8),
    .i_keep(k8), .o_crc(crc8), .o_crc_valid(val8), .o_abort(abt8), .o_crc_ok(ok8)
  );

  crc32_parallel #(.P_DW(32)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_en(en32), .i_sof(sof32), .i_eof(eof32), .i_data(d32),
    .i_keep(k32), .o_crc(crc32), .o_crc_valid(val32), .o_abort(abt32), .o_crc_ok(ok32)
  );

  crc32_parallel #(.P_DW(64)) u_dut64 (
    .i_clk(clk), .i_rst(rst), .i_en(en64), .i_sof(sof64), .i_eof(eof64), .i_data(d64),
    .i_keep(k64), .o_crc(crc64), .o_crc_valid(val64), .o_abort(abt64), .o_crc_ok(ok64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic b8(input logic sof, input logic eof, input logic [7:0] d, input logic k);
    en8 = 1'b1; sof8 = sof; eof8 = eof; d8 = d; k8 = k;
    @(posedge clk); #1;
    en8 = 1'b0; sof8 = 1'b0; eof8 = 1'b0;
  endtask

  task automatic b32(input logic sof, input logic eof, input logic [31:0] d, input logic [3:0] k);
    en32 = 1'b1; sof32 = sof; eof32 = eof; d32 = d; k32 = k;
    @(posedge clk); #1;
    en32 = 1'b0; sof32 = 1'b0; eof32 = 1'b0;
  endtask

  task automatic b64(input logic sof, input logic eof, input logic [63:0] d, input logic [7:0] k);
    en64 = 1'b1; sof64 = sof; eof64 = eof; d64 = d; k64 = k;
    @(posedge clk); #1;
    en64 = 1'b0; sof64 = 1'b0; eof64 = 1'b0;
  endtask

  task automatic idle;
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    s9  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fcs = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    en8 = 0; sof8 = 0; eof8 = 0; d8 = 0; k8 = 0;
    en32 = 0; sof32 = 0; eof32 = 0; d32 = 0; k32 = 0;
    en64 = 0; sof64 = 0; eof64 = 0; d64 = 0; k64 = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_crc8", crc8, 32'h0);
    chk("rst_val8", {31'b0, val8}, 32'h0);
    chk("rst_abt8", {31'b0, abt8}, 32'h0);
    chk("rst_ok8", {31'b0, ok8}, 32'h0);
    chk("rst_crc32", crc32, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single zero byte, sof+eof together.
    b8(1'b1, 1'b1, 8'h00, 1'b1);
    chk("zero_val", {31'b0, val8}, 32'h1);
    chk("zero_crc", crc8, 32'hD202EF8D);
    idle();
    chk("zero_val_pulse", {31'b0, val8}, 32'h0);
    chk("zero_hold", crc8, 32'hD202EF8D);

    // Check string, no gaps.
    for (int i = 0; i < 9; i++) b8(i == 0, i == 8, s9[i], 1'b1);
    chk("s9_val", {31'b0, val8}, 32'h1);
    chk("s9_crc", crc8, 32'hCBF43926);

    // Non-sof beat in idle is ignored.
    b8(1'b0, 1'b1, 8'hAA, 1'b1);
    chk("idle_ign_val", {31'b0, val8}, 32'h0);
    chk("idle_ign_crc", crc8, 32'hCBF43926);

    // Check string with i_en gaps.
    for (int i = 0; i < 9; i++) begin
      b8(i == 0, i == 8, s9[i], 1'b1);
      if (i == 8) begin
        chk("gap_val", {31'b0, val8}, 32'h1);
        chk("gap_crc", crc8, 32'hCBF43926);
      end else begin
        idle();
        chk("gap_noval", {31'b0, val8}, 32'h0);
      end
    end

    // Closing beat with keep=0 contributes nothing.
    for (int i = 0; i < 9; i++) b8(i == 0, 1'b0, s9[i], 1'b0);
    b8(1'b0, 1'b1, 8'hFF, 1'b0);
    chk("keep0_val", {31'b0, val8}, 32'h1);
    chk("keep0_crc", crc8, 32'hCBF43926);

    // Restart mid-frame.
    b8(1'b1, 1'b0, 8'h61, 1'b1);
    chk("run_a_crc", crc8, 32'hE8B7BE43);
    chk("run_a_val", {31'b0, val8}, 32'h0);
    b8(1'b0, 1'b0, 8'h62, 1'b1);
    b8(1'b1, 1'b0, s9[0], 1'b1);
    chk("abort_pulse", {31'b0, abt8}, 32'h1);
    chk("abort_noval", {31'b0, val8}, 32'h0);
    for (int i = 1; i < 9; i++) begin
      b8(1'b0, i == 8, s9[i], 1'b1);
      if (i == 1) chk("abort_clear", {31'b0, abt8}, 32'h0);
    end
    chk("abort_new_val", {31'b0, val8}, 32'h1);
    chk("abort_new_crc", crc8, 32'hCBF43926);

    // Back-to-back frames.
    for (int i = 0; i < 9; i++) b8(i == 0, i == 8, s9[i], 1'b1);
    chk("b2b_val1", {31'b0, val8}, 32'h1);
    chk("b2b_crc1", crc8, 32'hCBF43926);
    b8(1'b1, 1'b1, 8'h61, 1'b1);
    chk("b2b_val2", {31'b0, val8}, 32'h1);
    chk("b2b_crc2", crc8, 32'hE8B7BE43);
    chk("b2b_noabort", {31'b0, abt8}, 32'h0);

    // Frame including its FCS, then with one data bit flipped.
    for (int i = 0; i < 9; i++) b8(i == 0, 1'b0, s9[i], 1'b1);
    for (int j = 0; j < 4; j++) b8(1'b0, j == 3, fcs[j], 1'b1);
    chk("fcs_val", {31'b0, val8}, 32'h1);
    chk("fcs_crc", crc8, 32'h2144DF1C);
    chk("fcs_ok", {31'b0, ok8}, {31'b0, ExpOk});
    idle();
    chk("fcs_ok_pulse", {31'b0, ok8}, 32'h0);
    for (int i = 0; i < 9; i++) b8(i == 0, 1'b0, (i == 0) ? 8'h30 : s9[i], 1'b1);
    for (int j = 0; j < 4; j++) b8(1'b0, j == 3, fcs[j], 1'b1);
    chk("flip_val", {31'b0, val8}, 32'h1);
    chk("flip_ok", {31'b0, ok8}, 32'h0);

    // Reset mid-frame: outputs clear at once and the tail never completes.
    b8(1'b1, 1'b0, s9[0], 1'b1);
    b8(1'b0, 1'b0, s9[1], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_crc", crc8, 32'h0);
    chk("mrst_val", {31'b0, val8}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    b8(1'b0, 1'b0, s9[2], 1'b1);
    b8(1'b0, 1'b1, s9[3], 1'b1);
    chk("mrst_tail_val", {31'b0, val8}, 32'h0);
    chk("mrst_tail_crc", crc8, 32'h0);
    idle();
    chk("mrst_tail_val2", {31'b0, val8}, 32'h0);

    // 32-bit path.
    b32(1'b1, 1'b0, 32'h34333231, 4'h0);
    b32(1'b0, 1'b0, 32'h38373635, 4'h0);
    b32(1'b0, 1'b1, 32'hAAAAAA39, 4'b0001);
    chk("w32_val", {31'b0, val32}, 32'h1);
    chk("w32_crc", crc32, 32'hCBF43926);
    b32(1'b1, 1'b1, 32'h55555500, 4'b0001);
    chk("w32_zero_crc", crc32, 32'hD202EF8D);
    b32(1'b1, 1'b0, 32'h34333231, 4'hF);
    b32(1'b0, 1'b0, 32'h38373635, 4'hF);
    b32(1'b0, 1'b0, 32'hF4392639, 4'hF);
    b32(1'b0, 1'b1, 32'h000000CB, 4'b0001);
    chk("w32_fcs_crc", crc32, 32'h2144DF1C);
    chk("w32_fcs_ok", {31'b0, ok32}, {31'b0, ExpOk});

    // 64-bit path; keep on the first beat is ignored.
    b64(1'b1, 1'b0, 64'h3837363534333231, 8'h00);
    b64(1'b0, 1'b1, 64'hFFFFFFFFFFFFFF39, 8'h01);
    chk("w64_val", {31'b0, val64}, 32'h1);
    chk("w64_crc", crc64, 32'hCBF43926);
    idle();
    chk("w64_val_pulse", {31'b0, val64}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
